// File: rtl/fft_pkg.sv
// Shared types and sizes for the fft8 datapath.
// Every stage around fft8 builds on these.
package fft_pkg;

  localparam int DATA_W = 32;
  localparam int FFT_N = 8;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/frame_bank.sv
// One frame of sample registers.
// Single write port, all slots read in parallel.
module frame_bank
  import fft_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int N = FFT_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   addr,
  input  logic [W-1:0]           d,
  output logic [N-1:0][W-1:0]    q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q[addr] <= d;
    end
  end

endmodule

// File: rtl/fft8_frame_loader.sv
// Packs a serial sample stream into 8-sample frames
// held in a ping-pong pair of banks for the fft8 core.
module fft8_frame_loader #(
  parameter int DATA_W  = fft_pkg::DATA_W,
  parameter int FRAME_N = fft_pkg::FFT_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_first,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] A0,
  output logic [DATA_W-1:0] A1,
  output logic [DATA_W-1:0] A2,
  output logic [DATA_W-1:0] A3,
  output logic [DATA_W-1:0] A4,
  output logic [DATA_W-1:0] A5,
  output logic [DATA_W-1:0] A6,
  output logic [DATA_W-1:0] A7,
  output logic              resync_err
);

  localparam int IW = $clog2(FRAME_N);
  localparam logic [IW-1:0] LAST = IW'(FRAME_N - 1);

  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [IW-1:0] idx;
  logic [IW-1:0] slot;
  logic          acc;
  logic          take;

  logic [FRAME_N-1:0][DATA_W-1:0] q0;
  logic [FRAME_N-1:0][DATA_W-1:0] q1;
  logic [FRAME_N-1:0][DATA_W-1:0] rq;

  assign s_ready     = !full[wr_sel];
  assign frame_valid = full[rd_sel];
  assign acc         = s_valid && s_ready;
  assign take        = frame_valid && frame_ready;
  // a start marker always restarts at slot 0
  assign slot        = s_first ? '0 : idx;

  frame_bank #(.W(DATA_W), .N(FRAME_N)) u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .we   (acc && !wr_sel),
    .addr (slot),
    .d    (s_data),
    .q    (q0)
  );

  frame_bank #(.W(DATA_W), .N(FRAME_N)) u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .we   (acc && wr_sel),
    .addr (slot),
    .d    (s_data),
    .q    (q1)
  );

  assign rq = rd_sel ? q1 : q0;
  assign A0 = rq[0];
  assign A1 = rq[1];
  assign A2 = rq[2];
  assign A3 = rq[3];
  assign A4 = rq[4];
  assign A5 = rq[5];
  assign A6 = rq[6];
  assign A7 = rq[7];

  // set and clear never hit the same flag: a filling bank is never full
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 2'b00;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      idx        <= '0;
      resync_err <= 1'b0;
    end else begin
      resync_err <= acc && s_first && (idx != '0);
      if (acc) begin
        if (slot == LAST) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          idx          <= '0;
        end else begin
          idx <= slot + 1'b1;
        end
      end
      if (take) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed and throttled-stream checks for fft8_frame_loader.
// Inputs change and outputs are sampled on the falling edge.
module tb_fft8_frame_loader;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_first;
  logic [31:0] s_data;
  logic        s_ready;
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic        resync_err;

  int checks = 0;
  int errors = 0;

  fft8_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_first     (s_first),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .A0          (A0),
    .A1          (A1),
    .A2          (A2),
    .A3          (A3),
    .A4          (A4),
    .A5          (A5),
    .A6          (A6),
    .A7          (A7),
    .resync_err  (resync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] frm();
    return {A0, A1, A2, A3, A4, A5, A6, A7};
  endfunction

  function automatic logic [255:0] seq(input int b);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'(b + i)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one sample; returns after the edge that accepts it
  task automatic send(input int d, input logic first);
    int n;
    s_valid = 1'b1;
    s_data  = 32'(d);
    s_first = first;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [255:0] e;
    int sent;
    int frames;
    int cyc;

    rst = 1'b1;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data = '0;
    frame_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_fv", frame_valid, 0);
    chk("rst_rdy", s_ready, 1);
    chk("rst_frame", frm(), 0);
    chk("rst_err", resync_err, 0);

    // single frame, downstream always ready
    frame_ready = 1'b1;
    send(0, 1); send(43, 0); send(78, 0); send(97, 0);
    send(97, 0); send(78, 0); send(43, 0);
    chk("t1_fv_early", frame_valid, 0);
    send(0, 0);
    chk("t1_fv", frame_valid, 1);
    chk("t1_frame", frm(),
        {32'd0, 32'd43, 32'd78, 32'd97, 32'd97, 32'd78, 32'd43, 32'd0});
    @(negedge clk);
    chk("t1_fv_one", frame_valid, 0);
    frame_ready = 1'b0;

    // two back-to-back frames with downstream stalled
    for (int i = 1; i <= 16; i++) send(i, (i == 1) || (i == 9));
    chk("t2_full_rdy", s_ready, 0);
    chk("t2_fv", frame_valid, 1);
    chk("t2_frame1", frm(), seq(1));
    pulse_ready();
    chk("t2_frame2", frm(), seq(9));
    chk("t2_rdy", s_ready, 1);
    chk("t2_fv2", frame_valid, 1);
    pulse_ready();
    chk("t2_drained", frame_valid, 0);

    // resync truncates a partial frame
    send(5, 1); send(6, 0); send(7, 0);
    chk("t3_err_quiet", resync_err, 0);
    send(100, 1);
    chk("t3_err", resync_err, 1);
    send(101, 0);
    chk("t3_err_once", resync_err, 0);
    for (int i = 102; i <= 107; i++) send(i, 0);
    chk("t3_fv", frame_valid, 1);
    chk("t3_frame", frm(), seq(100));

    // frame B completes on the edge that consumes frame A
    send(200, 1);
    for (int i = 201; i <= 206; i++) send(i, 0);
    chk("t4_a_held", frm(), seq(100));
    frame_ready = 1'b1;
    send(207, 0);
    frame_ready = 1'b0;
    chk("t4_fv", frame_valid, 1);
    chk("t4_frame", frm(), seq(200));
    chk("t4_rdy", s_ready, 1);
    pulse_ready();
    chk("t4_drained", frame_valid, 0);

    // reset with a frame pending and a partial frame
    for (int i = 1; i <= 8; i++) send(i, i == 1);
    for (int i = 11; i <= 15; i++) send(i, i == 11);
    chk("t5_pending", frame_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_fv", frame_valid, 0);
    chk("t5_rdy", s_ready, 1);
    chk("t5_frame", frm(), 0);
    for (int i = 21; i <= 28; i++) send(i, i == 21);
    chk("t5_fv2", frame_valid, 1);
    chk("t5_frame2", frm(), seq(21));
    pulse_ready();
    chk("t5_drained", frame_valid, 0);

    // random throttling, 1000 samples = 125 frames
    sent = 0;
    frames = 0;
    cyc = 0;
    while (frames < 125 && cyc < 20000) begin
      s_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
      s_first = (sent % 8) == 0;
      s_data = $urandom;
      frame_ready = $urandom_range(0, 9) < 6;
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent++;
      end
      if (frame_valid && frame_ready) begin
        e = '0;
        for (int i = 0; i < 8; i++)
          e = {e[223:0], (q.size() > 0) ? q.pop_front() : 32'hdead_beef};
        chk("rnd_frame", frm(), e);
        chk("rnd_err", resync_err, 0);
        frames++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    frame_ready = 1'b0;
    chk("rnd_frames", 32'(frames), 125);
    chk("rnd_left", 32'(q.size()), 0);
    @(negedge clk);
    chk("rnd_fv_end", frame_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
